// File: rtl/ball_render_pkg.sv
// Shared constants and helpers for the ball sprite renderer: the circular
// mask, the ball start position and the colour-cycle mapping.
package ball_render_pkg;

    localparam int COORD_W = 10;
    localparam int RGB_W   = 3;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [RGB_W-1:0]   rgb_t;

    // Must match the position updater's start position.
    localparam coord_t BALL_X0 = 10'd156;
    localparam coord_t BALL_Y0 = 10'd232;

    // Stage-1 payload carried to the compositing stage.
    typedef struct packed {
        logic       inbox;
        logic [3:0] dx;
        logic [3:0] dy;
        logic       active;
        rgb_t       rgb;
    } s1_t;

    // One 16-bit mask row; bit 15 is the left-most pixel.
    function automatic logic [15:0] ball_mask_row(input logic [3:0] row);
        logic [15:0] bits;
        // NOTE: every arm (and the default) assigns the result, so this stays
        // purely combinational with no latch inferred.
        case (row)
            4'd0, 4'd15:         bits = 16'h07E0;
            4'd1, 4'd14:         bits = 16'h1FF8;
            4'd2, 4'd13:         bits = 16'h3FFC;
            4'd3, 4'd4,
            4'd11, 4'd12:        bits = 16'h7FFE;
            default:             bits = 16'hFFFF;
        endcase
        return bits;
    endfunction

    // Index 0 maps to white so the ball is never invisible black.
    function automatic rgb_t ball_colour(input logic [2:0] cidx);
        return (cidx == 3'd0) ? 3'b111 : cidx;
    endfunction

endpackage

// File: rtl/ball_sprite_rom.sv
// Combinational 16x16 lookup of the circular ball sprite mask.
module ball_sprite_rom
    import ball_render_pkg::*;
(
    input  logic [3:0] row,
    input  logic [3:0] col,
    output logic       pix
);

    logic [15:0] w_bits;

    assign w_bits = ball_mask_row(row);
    assign pix    = w_bits[4'd15 - col];

endmodule

// File: rtl/ball_render.sv
// Overlays the 16x16 ball sprite on the background pixel stream with a fixed
// two-cycle latency, using a ball position snapshotted once per frame.
module ball_render
    import ball_render_pkg::*;
#(
    parameter int unsigned SIZE_BALL    = 16,
    parameter int unsigned VISIBLECOLS  = 640,
    parameter int unsigned VISIBLEROWS  = 480,
    parameter int unsigned CYCLE_FRAMES = 64
) (
    input  logic         px_clk,
    input  logic         reset,
    input  logic         endframe,
    input  logic [9:0]   x_ball,
    input  logic [9:0]   y_ball,
    input  logic [9:0]   x_px,
    input  logic [9:0]   y_px,
    input  logic         active,
    input  logic [2:0]   rgb_in,
    output logic [2:0]   rgb_out,
    output logic         active_out
);

    localparam coord_t     BALL_EDGE = coord_t'(SIZE_BALL);
    localparam coord_t     LIM_X     = coord_t'(VISIBLECOLS);
    localparam coord_t     LIM_Y     = coord_t'(VISIBLEROWS);
    localparam logic [7:0] FCNT_LAST = 8'(CYCLE_FRAMES - 1);

    coord_t     r_xs;
    coord_t     r_ys;
    logic [7:0] r_fcnt;
    logic [2:0] r_cidx;
    s1_t        r_s1;

    coord_t     w_dx;
    coord_t     w_dy;
    logic       w_inbox;
    logic       w_pix;
    rgb_t       w_ball_rgb;

    // Frame-rate state: position snapshot and colour-cycle counters.
    // NOTE: state registers use non-blocking assignments so every block
    // samples the pre-edge values, which is what lets a pixel coinciding with
    // endframe still see the old position.
    always_ff @(posedge px_clk) begin
        if (reset) begin
            r_xs   <= BALL_X0;
            r_ys   <= BALL_Y0;
            r_fcnt <= '0;
            r_cidx <= '0;
        end else if (endframe) begin
            r_xs <= x_ball;
            r_ys <= y_ball;
            if (r_fcnt == FCNT_LAST) begin
                r_fcnt <= '0;
                r_cidx <= r_cidx + 3'd1;
            end else begin
                r_fcnt <= r_fcnt + 8'd1;
            end
        end
    end

    // Pixels left of / above the ball wrap to large offsets and miss. The
    // visible-area bounds only matter if active is ever asserted off-screen.
    always_comb begin
        w_dx    = x_px - r_xs;
        w_dy    = y_px - r_ys;
        w_inbox = (w_dx < BALL_EDGE) && (w_dy < BALL_EDGE) && active
                  && (x_px < LIM_X) && (y_px < LIM_Y);
    end

    always_ff @(posedge px_clk) begin
        if (reset) begin
            r_s1 <= '0;
        end else begin
            r_s1 <= '{inbox:  w_inbox,
                      dx:     w_dx[3:0],
                      dy:     w_dy[3:0],
                      active: active,
                      rgb:    rgb_in};
        end
    end

    ball_sprite_rom u_rom (
        .row (r_s1.dy),
        .col (r_s1.dx),
        .pix (w_pix)
    );

    assign w_ball_rgb = ball_colour(r_cidx);

    always_ff @(posedge px_clk) begin
        if (reset) begin
            rgb_out    <= '0;
            active_out <= 1'b0;
        end else begin
            if (r_s1.inbox && w_pix)
                rgb_out <= w_ball_rgb;
            else
                rgb_out <= r_s1.active ? r_s1.rgb : 3'b000;
            active_out <= r_s1.active;
        end
    end

endmodule

// File: tb/tb_ball_render.sv
// Directed bench for ball_render: streams pixels one per cycle and checks each
// output two cycles later against hand-computed colours.
module tb_ball_render;

    logic       px_clk = 1'b0;
    logic       reset;
    logic       endframe;
    logic [9:0] x_ball, y_ball, x_px, y_px;
    logic       active;
    logic [2:0] rgb_in;
    logic [2:0] rgb_out;
    logic       active_out;

    int n_total = 0;
    int n_bad   = 0;

    // Expectation of the pixel driven on the previous step.
    logic [2:0] s_rgb;
    logic       s_act;
    bit         s_chk;
    string      s_tag;
    int         s_x, s_y;

    ball_render dut (
        .px_clk     (px_clk),
        .reset      (reset),
        .endframe   (endframe),
        .x_ball     (x_ball),
        .y_ball     (y_ball),
        .x_px       (x_px),
        .y_px       (y_px),
        .active     (active),
        .rgb_in     (rgb_in),
        .rgb_out    (rgb_out),
        .active_out (active_out)
    );

    always #5 px_clk = ~px_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, want);
        end
    endtask

    // Drive one pixel for one cycle; checks the pixel from the previous step,
    // whose result is due on this edge (two edges after it was driven).
    task automatic step(input int x, input int y, input logic act, input logic [2:0] rgb,
                        input logic ef, input logic [2:0] e_rgb, input logic e_act,
                        input bit chk, input string tag);
        x_px     = 10'(x);
        y_px     = 10'(y);
        active   = act;
        rgb_in   = rgb;
        endframe = ef;
        @(posedge px_clk);
        @(negedge px_clk);
        if (s_chk) begin
            check($sformatf("%s_rgb(%0d,%0d)", s_tag, s_x, s_y), 32'(rgb_out), 32'(s_rgb));
            check($sformatf("%s_act(%0d,%0d)", s_tag, s_x, s_y), 32'(active_out), 32'(s_act));
        end
        s_rgb    = e_rgb;
        s_act    = e_act;
        s_chk    = chk;
        s_tag    = tag;
        s_x      = x;
        s_y      = y;
        endframe = 1'b0;
    endtask

    task automatic flush();
        step(0, 0, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, "idle");
    endtask

    task automatic pulse_ef(input int xb, input int yb);
        x_ball = 10'(xb);
        y_ball = 10'(yb);
        step(0, 0, 1'b0, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, "ef");
    endtask

    // One reset cycle; outputs must be cleared right after it, and the next
    // edge still shows the cleared pipeline.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        @(posedge px_clk);
        @(negedge px_clk);
        check({tag, "_rgb"}, 32'(rgb_out), 32'd0);
        check({tag, "_act"}, 32'(active_out), 32'd0);
        reset    = 1'b0;
        endframe = 1'b0;
        s_rgb    = 3'b000;
        s_act    = 1'b0;
        s_chk    = 1'b1;
        s_tag    = {tag, "_blank"};
        s_x      = 0;
        s_y      = 0;
    endtask

    function automatic logic [2:0] hit(input bit h, input logic [2:0] ball, input logic [2:0] bg);
        return h ? ball : bg;
    endfunction

    initial begin
        reset    = 1'b1;
        endframe = 1'b0;
        x_ball   = '0;
        y_ball   = '0;
        x_px     = '0;
        y_px     = '0;
        active   = 1'b0;
        rgb_in   = '0;
        s_chk    = 1'b0;
        @(negedge px_clk);
        do_reset("reset");

        // Ball at (100,50): mask row 0 covers columns 105..110.
        pulse_ef(100, 50);
        for (int x = 95; x <= 120; x++)
            step(x, 50, 1'b1, 3'b001, 1'b0, hit(x >= 105 && x <= 110, 3'b111, 3'b001), 1'b1, 1'b1, "row50");
        // Mask row 7 is solid: columns 100..115.
        for (int x = 98; x <= 117; x++)
            step(x, 57, 1'b1, 3'b001, 1'b0, hit(x >= 100 && x <= 115, 3'b111, 3'b001), 1'b1, 1'b1, "row57");
        // Blanking forces black even on the sprite.
        step(105, 57, 1'b0, 3'b011, 1'b0, 3'b000, 1'b0, 1'b1, "blank_on_ball");
        flush();

        // Bottom-right corner, no wrap onto the opposite edges.
        pulse_ef(624, 464);
        for (int x = 620; x <= 639; x++)
            step(x, 471, 1'b1, 3'b010, 1'b0, hit(x >= 624, 3'b111, 3'b010), 1'b1, 1'b1, "right");
        for (int y = 460; y <= 479; y++)
            step(631, y, 1'b1, 3'b010, 1'b0, hit(y >= 464, 3'b111, 3'b010), 1'b1, 1'b1, "bottom");
        step(0, 464, 1'b1, 3'b010, 1'b0, 3'b010, 1'b1, 1'b1, "nowrap_x");
        step(624, 0, 1'b1, 3'b010, 1'b0, 3'b010, 1'b1, 1'b1, "nowrap_y");
        step(15, 471, 1'b1, 3'b010, 1'b0, 3'b010, 1'b1, 1'b1, "nowrap_x2");
        flush();

        // endframe coinciding with an active pixel: that pixel sees xs=100.
        pulse_ef(100, 50);
        x_ball = 10'd300;
        step(105, 50, 1'b1, 3'b001, 1'b1, 3'b111, 1'b1, 1'b1, "ef_same_px");
        step(105, 50, 1'b1, 3'b001, 1'b0, 3'b001, 1'b1, 1'b1, "old_pos_gone");
        for (int x = 300; x <= 315; x++)
            step(x, 50, 1'b1, 3'b001, 1'b0, hit(x >= 305 && x <= 310, 3'b111, 3'b001), 1'b1, 1'b1, "moved");
        flush();

        // Colour cycling: one colour step per 64 frames, 8 steps per lap.
        do_reset("reset2");
        for (int k = 1; k <= 576; k++) begin
            logic [2:0] want;
            bit         probe;
            pulse_ef(100, 50);
            probe = 1'b1;
            case (k)
                63:      want = 3'b111;
                64:      want = 3'b001;
                128:     want = 3'b010;
                384:     want = 3'b110;
                511:     want = 3'b111;
                512:     want = 3'b111;
                576:     want = 3'b001;
                default: begin want = 3'b000; probe = 1'b0; end
            endcase
            if (probe)
                step(105, 50, 1'b1, 3'b000, 1'b0, want, 1'b1, 1'b1, $sformatf("colour_after_%0d", k));
        end
        flush();

        // Mid-scan reset with the ball (colour 1) under the scan; endframe
        // during reset must not load x_ball.
        step(105, 50, 1'b1, 3'b010, 1'b0, 3'b001, 1'b1, 1'b1, "pre_rst");
        step(106, 50, 1'b1, 3'b010, 1'b0, 3'b001, 1'b1, 1'b1, "pre_rst");
        x_ball   = 10'd300;
        y_ball   = 10'd50;
        endframe = 1'b1;
        x_px     = 10'd107;
        do_reset("rst_mid");
        step(108, 50, 1'b1, 3'b010, 1'b0, 3'b010, 1'b1, 1'b1, "post_rst_old");
        for (int x = 155; x <= 172; x++)
            step(x, 232, 1'b1, 3'b100, 1'b0, hit(x >= 161 && x <= 166, 3'b111, 3'b100), 1'b1, 1'b1, "home_row0");
        for (int x = 155; x <= 172; x++)
            step(x, 239, 1'b1, 3'b100, 1'b0, hit(x >= 156 && x <= 171, 3'b111, 3'b100), 1'b1, 1'b1, "home_row7");
        flush();

        // Frame counter restarted by reset: colour steps on the 64th pulse.
        for (int k = 1; k <= 64; k++) begin
            pulse_ef(156, 232);
            if (k == 63)
                step(161, 232, 1'b1, 3'b000, 1'b0, 3'b111, 1'b1, 1'b1, "fcnt_63");
            if (k == 64)
                step(161, 232, 1'b1, 3'b000, 1'b0, 3'b001, 1'b1, 1'b1, "fcnt_64");
        end
        flush();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ball_render.md
# ball_render

Pixel-domain consumer of the ball position. It snapshots `x_ball`/`y_ball` once per frame at `endframe` and compares each incoming pixel coordinate against the snapshot. Where the pixel falls on the ball's 16×16 circular sprite, it overlays the ball colour on the background RGB. It sits between the video timing generator and the RGB output stage, downstream of the ball-position updater.

## Interface
Parameters:
- `SIZE_BALL`, default 16: sprite edge in pixels. Only 16 is supported; the mask ROM is 16×16.
- `VISIBLECOLS`, default 640: visible columns.
- `VISIBLEROWS`, default 480: visible rows.
- `CYCLE_FRAMES`, default 64: frames per ball-colour step. Must be 1–255.

Ports:
- `px_clk` in 1: pixel clock, the only clock.
- `reset` in 1: synchronous, active-high.
- `endframe` in 1: one-cycle end-of-frame strobe.
- `x_ball` in 10: ball left column from the position updater.
- `y_ball` in 10: ball top row from the position updater.
- `x_px` in 10: current pixel column.
- `y_px` in 10: current pixel row.
- `active` in 1: current pixel is visible.
- `rgb_in` in 3: background colour {r,g,b}.
- `rgb_out` out 3: composited colour.
- `active_out` out 1: `active` delayed to match `rgb_out`.

## Operation
- Shadow registers `xs`, `ys` (10 bit):
  - Load `x_ball`, `y_ball` on a clock edge where `endframe`=1; otherwise hold.
  - Reset values: `xs`=156, `ys`=232, matching the updater's start position.
- Frame counter `fcnt` (8 bit) and colour index `cidx` (3 bit), both updated on `endframe`:
  - If `fcnt`=`CYCLE_FRAMES`−1, then `fcnt`←0 and `cidx`←`cidx`+1, wrapping 7→0.
  - Otherwise `fcnt`←`fcnt`+1.
  - Both reset to 0.
- Ball colour: 3'b111 when `cidx`=0, else `cidx`.
- Stage 1 (registered):
  - `dx` = `x_px`−`xs` and `dy` = `y_px`−`ys`, each 10-bit unsigned with natural wrap.
  - `inbox` = (`dx`<16) && (`dy`<16) && `active`. A pixel left of or above the ball wraps to a large value and misses.
  - Register `inbox`, `dx[3:0]`, `dy[3:0]`, `active`, `rgb_in`.
- Stage 2 (registered):
  - `mask` = `BALL_MASK[dy][15−dx]`, with bit 15 the left-most pixel.
  - `rgb_out` = (`inbox` && `mask`) ? ball colour : (`active` ? `rgb_in` : 3'b000).
  - `active_out` = stage-1 `active`.
- Mask rows 0..15, hex:
  - 07E0, 1FF8, 3FFC, 7FFE, 7FFE, FFFF, FFFF, FFFF
  - FFFF, FFFF, FFFF, 7FFE, 7FFE, 3FFC, 1FF8, 07E0
- Outside the active area `rgb_out` is forced to 0, even if the sprite overlaps.

## Timing
- Latency is 2 `px_clk` cycles from `x_px`/`y_px`/`active`/`rgb_in` to `rgb_out`/`active_out`. The pipeline runs fully, with no stalls and no handshake.
- Stage 1 uses the shadow values present before the edge. When `endframe` and `active` coincide, that pixel uses the old position. Every later pixel uses the new one.
- `fcnt` and `cidx` change on the `endframe` edge. The new colour applies to pixels entering stage 2 after that edge.
- Right edge: `xs`=624 gives hits on columns 624–639. The bottom edge behaves the same way with `ys`=464. Nothing wraps onto the opposite edge.
- `xs`≥`VISIBLECOLS`, from a garbage input, draws nothing visible. No clamping is done.
- Reset:
  - All pipeline registers are cleared: `rgb_out`=0, `active_out`=0.
  - Shadows, `fcnt` and `cidx` return to their reset values.
  - A reset asserted mid-frame blanks the output for 2 cycles after deassertion, then output resumes.
- Reset has priority over `endframe`.

## Structure
- Add to `Pxs.vh`:
  - `BALL_MASK` rows as 16-bit constants.
  - Reset positions `BALL_X0`=156, `BALL_Y0`=232.
  - RGB width (3).
- Sub-module `ball_sprite_rom` is a combinational 16×16 lookup: in `row[3:0]`, `col[3:0]`, out `pix`. It is instantiated in stage 2.
- Estimated size is about 150 RTL lines for the top module plus about 40 for the ROM.

## Test plan
- Reset, then `endframe` with `x_ball`=100, `y_ball`=50, then a sweep of row 50 with `rgb_in`=3'b001. Required: `rgb_out`=3'b111 on columns 105–110 only, appearing 2 cycles after each pixel, and 3'b001 elsewhere.
- Same position, row 57. Required: columns 100–115 are all ball; column 99 and column 116 show background.
- `x_ball`=624, `y_ball`=464, bottom-right scan. Required: hits on x 624–639 and y 464–479; pixels (0,464) and (624,0) show no hit.
- Drive `endframe` with `active`=1 at (100,50) while changing `x_ball` from 100 to 300. Required: that pixel uses `xs`=100; the next row's hits move to 305–310 and later.
- Issue 64 `endframe` pulses. Required: the ball colour changes 3'b111→3'b001 on the 64th. After 512 pulses `cidx` is back to 0.
- Assert `reset` mid-scan with the ball under the scan. Required: `rgb_out`/`active_out`=0 on the cycle after reset; the shadows read 156/232; the ball is drawn at (156,232) afterwards.
